// File: rtl/pzcorebus_upsizer_port_arbiter_if.sv
// Handshake bundle shared by the narrow-side masters, the upsizer and the port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric.
interface pzcorebus_upsizer_port_arbiter_if #(
  parameter int REQUESTERS  = 4,
  parameter int INDEX_WIDTH = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
);
  logic [REQUESTERS-1:0]  i_command_valid;
  logic [REQUESTERS-1:0]  i_command_write;
  logic [REQUESTERS-1:0]  i_command_non_posted;
  logic [REQUESTERS-1:0]  o_command_accept;
  logic [REQUESTERS-1:0]  i_data_valid;
  logic [REQUESTERS-1:0]  i_data_last;
  logic [REQUESTERS-1:0]  o_data_accept;
  logic [INDEX_WIDTH-1:0] o_grant_index;
  logic                   o_command_valid;
  logic                   i_command_accept;
  logic                   o_data_valid;
  logic                   i_data_accept;
  logic                   i_response_valid;
  logic                   i_response_last;
  logic                   o_response_accept;
  logic [INDEX_WIDTH-1:0] o_response_index;
  logic [REQUESTERS-1:0]  o_response_valid;
  logic [REQUESTERS-1:0]  i_response_accept;
  logic                   o_busy;

  modport slave (
    input  i_command_valid, i_command_write, i_command_non_posted,
    input  i_data_valid, i_data_last,
    input  i_command_accept, i_data_accept,
    input  i_response_valid, i_response_last, i_response_accept,
    output o_command_accept, o_data_accept, o_grant_index,
    output o_command_valid, o_data_valid,
    output o_response_accept, o_response_index, o_response_valid, o_busy
  );

  modport master (
    output i_command_valid, i_command_write, i_command_non_posted,
    output i_data_valid, i_data_last,
    output i_command_accept, i_data_accept,
    output i_response_valid, i_response_last, i_response_accept,
    input  o_command_accept, o_data_accept, o_grant_index,
    input  o_command_valid, o_data_valid,
    input  o_response_accept, o_response_index, o_response_valid, o_busy
  );
endinterface

// File: rtl/pzcorebus_upsizer_port_arbiter.sv
// Round-robin arbiter sharing one upsizer between REQUESTERS masters, with in-order response routing.
// Optional sticky protocol-error output: define PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN.
module pzcorebus_upsizer_port_arbiter #(
  parameter int REQUESTERS      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int INDEX_WIDTH     = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
)(
  input  logic i_clk,
  input  logic i_rst,
`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
  output logic o_error,
`endif
  pzcorebus_upsizer_port_arbiter_if.slave bus
);
  localparam int          QW    = $clog2(MAX_OUTSTANDING);
  localparam int          CW    = QW + 1;
  localparam int unsigned NREQ  = REQUESTERS;
  localparam int unsigned DEPTH = MAX_OUTSTANDING;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 r_state;
  logic [INDEX_WIDTH-1:0] r_grant_index;
  logic [INDEX_WIDTH-1:0] r_pointer;
  logic                   r_cmd_done;
  logic                   r_data_done;
  logic [INDEX_WIDTH-1:0] r_queue [MAX_OUTSTANDING];
  logic [QW-1:0]          r_head;
  logic [QW-1:0]          r_tail;
  logic [CW-1:0]          r_count;

  logic                   w_full, w_not_empty, w_locked, w_any_eligible;
  logic [REQUESTERS-1:0]  w_eligible;
  logic [INDEX_WIDTH-1:0] w_select, w_cand, w_head, w_next_pointer;
  logic                   w_command_valid, w_data_valid, w_cmd_hs, w_data_hs, w_last_hs;
  logic                   w_cmd_done_next, w_data_done_next, w_release;
  logic                   w_push, w_pop, w_response_accept, w_stray_response;
  logic [REQUESTERS-1:0]  w_command_accept, w_data_accept, w_response_valid;

  assign w_full      = r_count == CW'(MAX_OUTSTANDING);
  assign w_not_empty = r_count != '0;
  assign w_locked    = r_state == LOCKED;
  assign w_eligible  = bus.i_command_valid & ~(bus.i_command_non_posted & {REQUESTERS{w_full}});

  // First eligible requester at or after the round-robin pointer, wrapping.
  always_comb begin
    w_any_eligible = 1'b0;
    w_select       = '0;
    w_cand         = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = INDEX_WIDTH'((32'(r_pointer) + i) % NREQ);
      if (!w_any_eligible && w_eligible[w_cand]) begin
        w_any_eligible = 1'b1;
        w_select       = w_cand;
      end
    end
  end

  assign w_command_valid  = w_locked & bus.i_command_valid[r_grant_index] & ~r_cmd_done;
  assign w_data_valid     = w_locked & bus.i_data_valid[r_grant_index] & ~r_data_done;
  assign w_cmd_hs         = w_command_valid & bus.i_command_accept;
  assign w_data_hs        = w_data_valid & bus.i_data_accept;
  assign w_last_hs        = w_data_hs & bus.i_data_last[r_grant_index];
  assign w_cmd_done_next  = r_cmd_done | w_cmd_hs;
  assign w_data_done_next = r_data_done | w_last_hs;
  assign w_release        = w_locked & w_cmd_done_next & w_data_done_next;
  assign w_push           = w_cmd_hs & bus.i_command_non_posted[r_grant_index];
  assign w_next_pointer   = (r_grant_index == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : r_grant_index + 1'b1;

  always_comb begin
    w_command_accept                = '0;
    w_data_accept                   = '0;
    w_command_accept[r_grant_index] = w_cmd_hs;
    w_data_accept[r_grant_index]    = w_data_hs;
  end

  assign w_head = r_queue[r_head];
`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
  assign w_stray_response = bus.i_response_valid & ~w_not_empty;
`else
  assign w_stray_response = 1'b0;
`endif
  assign w_response_accept = (bus.i_response_accept[w_head] & w_not_empty) | w_stray_response;
  assign w_pop = bus.i_response_valid & bus.i_response_last & w_not_empty & bus.i_response_accept[w_head];

  always_comb begin
    w_response_valid         = '0;
    w_response_valid[w_head] = bus.i_response_valid & w_not_empty;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_grant_index <= '0;
      r_pointer     <= '0;
      r_cmd_done    <= 1'b0;
      r_data_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any_eligible) begin
          r_state       <= LOCKED;
          r_grant_index <= w_select;
          r_cmd_done    <= 1'b0;
          r_data_done   <= ~bus.i_command_write[w_select];
        end
        LOCKED: if (w_release) begin
          r_state     <= IDLE;
          r_pointer   <= w_next_pointer;
          r_cmd_done  <= 1'b0;
          r_data_done <= 1'b0;
        end else begin
          r_cmd_done  <= w_cmd_done_next;
          r_data_done <= w_data_done_next;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_queue[i] <= '0;
    end else begin
      if (w_push) begin
        r_queue[r_tail] <= r_grant_index;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
  logic r_read_grant;
  logic r_error;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_read_grant <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_any_eligible) r_read_grant <= ~bus.i_command_write[w_select];
      if (w_stray_response || (w_locked && r_read_grant && bus.i_data_valid[r_grant_index]))
        r_error <= 1'b1;
    end
  end

  assign o_error = r_error;
`endif

  assign bus.o_command_accept  = w_command_accept;
  assign bus.o_data_accept     = w_data_accept;
  assign bus.o_grant_index     = r_grant_index;
  assign bus.o_command_valid   = w_command_valid;
  assign bus.o_data_valid      = w_data_valid;
  assign bus.o_response_accept = w_response_accept;
  assign bus.o_response_index  = w_head;
  assign bus.o_response_valid  = w_response_valid;
  assign bus.o_busy            = w_locked | w_not_empty;
endmodule

// File: tb/tb_pzcorebus_upsizer_port_arbiter.sv
// Bench for pzcorebus_upsizer_port_arbiter: round-robin table, write bursts, queue-full blocking,
// response routing against an expected-requester queue, early data, async reset.
module tb_pzcorebus_upsizer_port_arbiter;
  localparam int R = 4;

  logic clk;
  logic rst;
`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
  logic err;
`endif

  pzcorebus_upsizer_port_arbiter_if #(.REQUESTERS(R), .INDEX_WIDTH(2)) bus ();

  pzcorebus_upsizer_port_arbiter #(.REQUESTERS(R), .MAX_OUTSTANDING(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
    .o_error (err),
`endif
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] write;
    int         exp_grant;
  } vec_t;

  vec_t vecs [8];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sb [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_command_valid      = '0;
    bus.i_command_write      = '0;
    bus.i_command_non_posted = '0;
    bus.i_data_valid         = '0;
    bus.i_data_last          = '0;
    bus.i_command_accept     = 1'b1;
    bus.i_data_accept        = 1'b1;
    bus.i_response_valid     = 1'b0;
    bus.i_response_last      = 1'b1;
    bus.i_response_accept    = '1;
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.o_command_valid, bus.o_data_valid, bus.o_response_accept, bus.o_busy,
                 bus.o_command_accept, bus.o_data_accept, bus.o_response_valid, bus.o_grant_index}, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #3;
    check_zero("reset_outputs");
`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
    check("reset_error", err, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cyc();
  endtask

  // Bounded wait for o_command_valid, then check the granted index.
  task automatic wait_cmd(input int exp, input string name);
    int n;
    n = 0;
    #1;
    while (!bus.o_command_valid && n < 20) begin
      cyc();
      #1;
      n++;
    end
    check({name, "_seen"}, bus.o_command_valid, 1);
    check({name, "_grant"}, bus.o_grant_index, exp);
  endtask

  initial begin
    int g, exp, ca, da;
    rst = 1'b1;
    idle_inputs();

    vecs[0] = '{4'b0101, 4'b0001, 0};
    vecs[1] = '{4'b0101, 4'b0100, 2};
    vecs[2] = '{4'b0101, 4'b0000, 0};
    vecs[3] = '{4'b1111, 4'b1010, 1};
    vecs[4] = '{4'b1000, 4'b1000, 3};
    vecs[5] = '{4'b0110, 4'b0010, 1};
    vecs[6] = '{4'b0011, 4'b0001, 0};
    vecs[7] = '{4'b1110, 4'b0100, 1};

    // Round-robin table: single-beat posted requests, command and data accepted together.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.i_command_valid = vecs[i].valid;
      bus.i_command_write = vecs[i].write;
      bus.i_data_valid    = vecs[i].write;
      bus.i_data_last     = vecs[i].write;
      cyc();
      #1;
      g = vecs[i].exp_grant;
      check("tbl_grant", bus.o_grant_index, g);
      check("tbl_cmd_valid", bus.o_command_valid, 1);
      check("tbl_cmd_accept", bus.o_command_accept, 4'b0001 << g);
      check("tbl_data_accept", bus.o_data_accept, vecs[i].write[g] ? (4'b0001 << g) : 4'b0000);
      cyc();
      idle_inputs();
      #1;
      check("tbl_release", {bus.o_command_valid, bus.o_busy}, 0);
    end

    // Requesters 0 and 2 posted writes; 4 beats from 0 lock the grant.
    do_reset();
    bus.i_command_valid = 4'b0101;
    bus.i_command_write = 4'b0101;
    bus.i_data_valid    = 4'b0101;
    cyc();
    for (int b = 1; b <= 4; b++) begin
      bus.i_data_last = (b == 4) ? 4'b0101 : 4'b0100;
      #1;
      check("wr4_grant", bus.o_grant_index, 0);
      check("wr4_data_accept", bus.o_data_accept, 4'b0001);
      check("wr4_cmd_valid", bus.o_command_valid, (b == 1) ? 1 : 0);
      cyc();
    end
    bus.i_command_valid = 4'b0100;
    bus.i_data_valid    = 4'b0100;
    bus.i_data_last     = 4'b0100;
    #1;
    check("wr4_gap", {bus.o_command_valid, bus.o_busy}, 0);
    cyc();
    #1;
    check("wr4_grant2", bus.o_grant_index, 2);
    check("wr4_grant2_accepts", {bus.o_command_accept, bus.o_data_accept}, 8'b0100_0100);
    cyc();
    idle_inputs();

    // Data-last two cycles ahead of the command handshake.
    do_reset();
    ca = 0;
    da = 0;
    bus.i_command_valid = 4'b0010;
    bus.i_command_write = 4'b0010;
    bus.i_data_valid    = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      bus.i_data_last      = (c == 3) ? 4'b0010 : 4'b0000;
      bus.i_command_accept = (c == 5);
      if (c >= 6) begin
        bus.i_command_valid = '0;
        bus.i_data_valid    = '0;
      end
      #1;
      ca += int'(bus.o_command_accept[1]);
      da += int'(bus.o_data_accept[1]);
      if (c == 1) check("early_grant", bus.o_grant_index, 1);
      if (c == 4) check("early_hold", {bus.o_command_valid, bus.o_data_valid, bus.o_busy}, 3'b101);
      if (c == 6) check("early_release", {bus.o_command_valid, bus.o_busy}, 0);
      cyc();
    end
    check("early_cmd_count", ca, 1);
    check("early_data_count", da, 3);

    // Async reset in the middle of a write burst with one read outstanding.
    do_reset();
    bus.i_command_valid      = 4'b0010;
    bus.i_command_non_posted = 4'b0010;
    wait_cmd(1, "rst_rd");
    cyc();
    bus.i_command_valid      = 4'b0100;
    bus.i_command_non_posted = 4'b0000;
    bus.i_command_write      = 4'b0100;
    bus.i_data_valid         = 4'b0100;
    wait_cmd(2, "rst_wr");
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    bus.i_command_valid  = 4'b0101;
    bus.i_command_write  = 4'b0000;
    bus.i_data_valid     = 4'b0000;
    bus.i_response_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    #1;
    check("rst_regrant", {bus.o_command_valid, bus.o_grant_index}, 3'b1_00);
    check("rst_queue_empty", {bus.o_response_valid, bus.o_response_index}, 0);

    // Non-posted reads from all four, queue full, posted write bypass, responses routed in order.
    do_reset();
    bus.i_command_valid      = 4'b1111;
    bus.i_command_non_posted = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      wait_cmd(r, "rd_rr");
      sb.push_back(r);
      cyc();
    end
    #1;
    check("full_busy", bus.o_busy, 1);
    cyc();
    cyc();
    #1;
    check("full_blocked", bus.o_command_valid, 0);
    bus.i_command_non_posted = 4'b0111;
    bus.i_command_write      = 4'b1000;
    bus.i_data_valid         = 4'b1000;
    bus.i_data_last          = 4'b1000;
    wait_cmd(3, "full_posted");
    check("full_posted_data", bus.o_data_accept, 4'b1000);
    cyc();
    bus.i_command_valid      = 4'b0001;
    bus.i_command_non_posted = 4'b0001;
    bus.i_command_write      = 4'b0000;
    bus.i_data_valid         = 4'b0000;
    bus.i_data_last          = 4'b0000;
    bus.i_response_valid     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 2) begin
        check("refill_grant", {bus.o_command_valid, bus.o_grant_index}, 3'b1_00);
        sb.push_back(0);
      end else begin
        check("rsp_cmd_idle", bus.o_command_valid, 0);
      end
      if (sb.size() == 0) begin
        check("rsp_expected_available", 0, 1);
      end else begin
        exp = sb.pop_front();
        check("rsp_onehot", bus.o_response_valid, 4'b0001 << exp);
        check("rsp_index", bus.o_response_index, exp);
        check("rsp_accept", bus.o_response_accept, 1);
      end
      cyc();
      if (k == 2) bus.i_command_valid = '0;
    end
    #1;
    check("empty_no_route", {bus.o_response_valid, bus.o_busy}, 0);
`ifdef PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN
    check("stray_drain", bus.o_response_accept, 1);
    cyc();
    bus.i_response_valid = 1'b0;
    #1;
    check("err_set", err, 1);
    cyc();
    cyc();
    #1;
    check("err_sticky", err, 1);
`else
    check("stray_stall", bus.o_response_accept, 0);
    cyc();
    #1;
    check("stray_stall_hold", bus.o_response_accept, 0);
`endif
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pzcorebus_upsizer_port_arbiter.md
Name: pzcorebus_upsizer_port_arbiter

Overview:
- Shares one pzcorebus_upsizer between REQUESTERS narrow-side masters.
- Round-robin arbitration; grant is locked for a whole request: command plus, for writes, every data beat through last.
- Records the requester of each non-posted command in an in-order routing queue and steers upsizer responses back to it.
- Control only: it drives the select for external command/data/response muxes and all valid/accept handshakes.

Parameters:
- REQUESTERS, 4, number of requesting ports; legal range 2..16.
- MAX_OUTSTANDING, 8, routing-queue depth, i.e. maximum non-posted commands awaiting response; power of 2, >=2.
- INDEX_WIDTH, max(1,$clog2(REQUESTERS)), width of the select indexes (derived, do not override).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_command_valid  in  REQUESTERS  per-requester command valid.
- i_command_write  in  REQUESTERS  command carries write data.
- i_command_non_posted  in  REQUESTERS  command expects a response.
- o_command_accept  out  REQUESTERS  per-requester command accept.
- i_data_valid  in  REQUESTERS  per-requester write-data valid.
- i_data_last  in  REQUESTERS  final write-data beat.
- o_data_accept  out  REQUESTERS  per-requester data accept.
- o_grant_index  out  INDEX_WIDTH  select for the external command/data mux.
- o_command_valid  out  1  to upsizer.
- i_command_accept  in  1  from upsizer.
- o_data_valid  out  1  to upsizer.
- i_data_accept  in  1  from upsizer.
- i_response_valid  in  1  from upsizer.
- i_response_last  in  1  final response beat.
- o_response_accept  out  1  to upsizer.
- o_response_index  out  INDEX_WIDTH  select for the response demux (queue head).
- o_response_valid  out  REQUESTERS  one-hot response valid.
- i_response_accept  in  REQUESTERS  per-requester response accept.
- o_busy  out  1  grant locked, or queue non-empty.

Behaviour:
- Reset (async, i_rst=1):
  - State IDLE; o_grant_index=0; round-robin pointer=0 (requester 0 highest priority).
  - cmd_done=0, data_done=0; queue empty (count=0).
  - Every valid and accept output 0; o_busy=0.
- Eligibility: requester r is eligible when i_command_valid[r]=1 AND NOT (i_command_non_posted[r]=1 AND count==MAX_OUTSTANDING).
- FSM IDLE:
  - If any requester is eligible, pick the first eligible index scanning from pointer upward, wrapping at REQUESTERS.
  - Register it into o_grant_index and go to LOCKED. Grant is visible the next cycle; request-to-o_command_valid latency is exactly 1 cycle.
  - Set data_done = NOT i_command_write[selected].
- FSM LOCKED (g = o_grant_index):
  - o_command_valid = i_command_valid[g] & !cmd_done; o_command_accept[g] = i_command_accept & o_command_valid.
  - o_data_valid = i_data_valid[g] & !data_done; o_data_accept[g] = i_data_accept & o_data_valid.
  - Command and data may handshake in the same cycle, or data before command; the upsizer aligner tolerates either order.
  - Command handshake sets cmd_done. If non-posted, push g into the queue in the same cycle.
  - Data handshake with i_data_last[g] sets data_done.
  - When cmd_done and data_done are both true (including the setting cycles): return to IDLE, set pointer=g+1 mod REQUESTERS, clear both flags.
  - Re-arbitration occurs in the next IDLE cycle, so there is a minimum 1-cycle gap between grants.
  - Non-granted accepts are always 0.
- Queue full while LOCKED: impossible for a granted non-posted command, which is eligibility-checked at grant time and is the only push source.
- Response routing:
  - o_response_index = queue head.
  - o_response_valid[head] = i_response_valid & (count!=0).
  - o_response_accept = i_response_accept[head] & (count!=0).
  - Pop on an accepted beat with i_response_last=1.
  - Simultaneous push and pop: count unchanged, head/tail both advance. Pointers wrap modulo MAX_OUTSTANDING.
- Response while queue empty: held unaccepted (o_response_accept=0); the upsizer stalls and nothing is routed.
- All outputs except o_grant_index are combinational from registered state plus inputs; no combinational path from i_command_accept to any o_*_valid.

Optional Feature:
- Macro: PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN.
- With the macro defined, the block adds:
  - Output port o_error (1 bit), sticky, cleared only by i_rst.
  - o_error sets when i_response_valid=1 while count==0.
  - o_error sets when i_data_valid[g]=1 in LOCKED for a read grant (data_done already 1 from grant).
  - In the empty-queue error case the stray response is drained (o_response_accept=1, no o_response_valid).
- Without the macro: no o_error port, and the empty-queue stall behaviour above applies.

Test Plan:
- Reset, then requesters 0 and 2 raise posted write commands at cycle 0 → o_grant_index=0 at cycle 1. Requester 0's 4 beats pass with last on beat 4 → return to IDLE → grant 2 one cycle later.
- All 4 requesters issue continuous single-beat non-posted reads → grants in order 0,1,2,3,0; queue holds 0,1,2,3. Responses return with last on every beat → o_response_valid one-hot 0001,0010,0100,1000.
- MAX_OUTSTANDING=2, requester 1 issues 3 non-posted reads with no responses → third read not granted. A posted write from requester 3 is granted meanwhile. The first response last pops the queue → third read granted next IDLE.
- Write where the data-last handshake precedes the command handshake by 2 cycles → grant held until the command handshake, then IDLE; exactly one command and 3 data accepts seen.
- Push and pop in the same cycle at count=2 → count stays 2. Assert i_rst mid-burst → all outputs 0 asynchronously, queue empty, next grant goes to requester 0.
- With PZCOREBUS_UPSIZER_ARBITER_ERROR_CHECK_EN defined: response valid with queue empty → o_error=1 next cycle and stays 1, response drained. Without the macro: response stalls with o_response_accept=0.
